// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming dig arbiter: FSM state encoding and
// dig length saturation helpers.
package lemmings_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        CONFIRM  = 3'd2,
        DIGGING  = 3'd3,
        COOLDOWN = 3'd4
    } state_e;

    localparam logic [7:0] LEN_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == LEN_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lemmings_dig_arbiter_if.sv
// Bundle between the player/walker side and the dig arbiter.
// The arbiter takes the slave view; whoever drives requests and walker status takes master.
interface lemmings_dig_arbiter_if #(
    parameter int N = 4
) ();
    localparam int W = $clog2(N);

    logic [N-1:0] dig_req;
    logic [N-1:0] digging;
    logic [N-1:0] dead;
    logic [N-1:0] dig_out;
    logic         busy;
    logic [W-1:0] owner;
    logic         done;
    logic         abort;
    logic [7:0]   last_len;

    modport master (
        output dig_req, digging, dead,
        input  dig_out, busy, owner, done, abort, last_len
    );

    modport slave (
        input  dig_req, digging, dead,
        output dig_out, busy, owner, done, abort, last_len
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    int           j;
    logic [W-1:0] jj;

    // Scan farthest offset first so the nearest eligible index wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            jj = W'(j);
            if (elig[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end
endmodule

// File: rtl/lemmings_dig_arbiter.sv
// Single dig permit, granted round-robin: pulse dig, confirm the walker started,
// hold until it falls through, then cool down before the next grant.
module lemmings_dig_arbiter
    import lemmings_pkg::*;
#(
    parameter int N            = 4,
    parameter int CONFIRM_WAIT = 2,
    parameter int COOLDOWN_CYC = 3
) (
    input  logic                  clk,
    input  logic                  areset,
    lemmings_dig_arbiter_if.slave bus
);
    localparam int W   = $clog2(N);
    localparam int CFW = $clog2(CONFIRM_WAIT + 1);
    localparam int CDW = $clog2(COOLDOWN_CYC + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   owner_q, owner_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   dig_out_q, dig_out_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;
    logic [7:0]     dig_cnt_q, dig_cnt_d;
    logic [7:0]     last_len_q, last_len_d;
    logic [CFW-1:0] conf_cnt_q, conf_cnt_d;
    logic [CDW-1:0] cd_cnt_q, cd_cnt_d;

    logic           found;
    logic [W-1:0]   pick;
    logic [W-1:0]   next_ptr;
    logic           own_dig, own_dead, kill;

    rr_pick #(.N(N), .W(W)) u_pick (
        .elig  (bus.dig_req & ~bus.dead),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    assign own_dig  = bus.digging[owner_q];
    assign own_dead = bus.dead[owner_q];
    assign next_ptr = (owner_q == W'(N - 1)) ? '0 : owner_q + W'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        dig_out_d  = '0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        dig_cnt_d  = dig_cnt_q;
        last_len_d = last_len_q;
        conf_cnt_d = conf_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        kill       = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                owner_d         = pick;
                dig_out_d[pick] = 1'b1;
                state_d         = ISSUE;
            end
            ISSUE: begin
                kill       = own_dead;
                state_d    = CONFIRM;
                conf_cnt_d = '0;
            end
            CONFIRM: begin
                if (own_dead) kill = 1'b1;
                else if (own_dig) begin
                    state_d   = DIGGING;
                    dig_cnt_d = 8'd1;
                end else if (conf_cnt_q == CFW'(CONFIRM_WAIT - 1)) kill = 1'b1;
                else conf_cnt_d = conf_cnt_q + CFW'(1);
            end
            DIGGING: begin
                if (own_dead) kill = 1'b1;
                else if (own_dig) dig_cnt_d = sat_inc(dig_cnt_q);
                else begin
                    last_len_d = dig_cnt_q;
                    done_d     = 1'b1;
                    ptr_d      = next_ptr;
                    state_d    = COOLDOWN;
                    cd_cnt_d   = '0;
                end
            end
            COOLDOWN: begin
                // The done cycle is cooldown slot 0, so COOLDOWN_CYC further idle cycles follow it.
                if (cd_cnt_q == CDW'(COOLDOWN_CYC)) state_d = IDLE;
                else cd_cnt_d = cd_cnt_q + CDW'(1);
            end
            default: state_d = IDLE;
        endcase
        // Owner death or confirm timeout ends the session without touching last_len.
        if (kill) begin
            state_d = IDLE;
            abort_d = 1'b1;
            ptr_d   = next_ptr;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            dig_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            dig_cnt_q  <= '0;
            last_len_q <= '0;
            conf_cnt_q <= '0;
            cd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            dig_out_q  <= dig_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            dig_cnt_q  <= dig_cnt_d;
            last_len_q <= last_len_d;
            conf_cnt_q <= conf_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
        end
    end

    assign bus.dig_out  = dig_out_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;
    assign bus.last_len = last_len_q;
endmodule

// File: tb/tb_lemmings_dig_arbiter.sv
// Directed and randomized dig sessions against a session-level model of the
// arbiter: who gets the permit, when the session ends, and how.
module tb_lemmings_dig_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    lemmings_dig_arbiter_if #(.N(N)) bus ();

    lemmings_dig_arbiter #(.N(N), .CONFIRM_WAIT(2), .COOLDOWN_CYC(3)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_cyc = -1;
    int         mptr     = 0;
    logic [7:0] mlen     = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Eligible indices in ascending order; take the first at or after p, else wrap to the smallest.
    function automatic int model_pick(input logic [N-1:0] elig, input int p);
        int q[$];
        for (int i = 0; i < N; i++) if (elig[i]) q.push_back(i);
        if (q.size() == 0) return -1;
        foreach (q[i]) if (q[i] >= p) return q[i];
        return q[0];
    endfunction

    // One session. d: confirm delay (0/1 rises, 2 never), L: cycles digging is high,
    // k: cycle (ISSUE=0) from which the owner is dead, -1 for never.
    task automatic session(input string tag, input logic [N-1:0] req, input logic [N-1:0] base_dead,
                           input int d, input int L, input int k);
        int         o, e, tend;
        bit         got, is_done, early;
        logic [N-1:0] ev;
        bus.dig_req = req;
        bus.dead    = base_dead;
        bus.digging = '0;
        o  = model_pick(req & ~base_dead, mptr);
        ev = '0;
        ev[o] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.dig_out != '0) got = 1'b1;
        end
        chk({tag, ".issued"}, 32'(got), 32'd1);
        if (!got) return;
        chk({tag, ".dig_out"}, 32'(bus.dig_out), 32'(ev));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
        chk({tag, ".busy_issue"}, 32'(bus.busy), 32'd1);
        if (done_cyc >= 0) chk({tag, ".cooldown_gap"}, 32'((cyc - done_cyc) >= 5), 32'd1);
        bus.dig_req = '0;
        e = (d <= 1) ? d + L + 1 : 2;
        if (k >= 0 && k <= e) begin
            tend    = k + 1;
            is_done = 1'b0;
        end else begin
            tend    = (d <= 1) ? d + L + 2 : 3;
            is_done = (d <= 1);
        end
        early = 1'b0;
        for (int t = 0; t < tend; t++) begin
            if (t > 0 && (bus.done || bus.abort)) early = 1'b1;
            if (t == 1) chk({tag, ".dig_out_width"}, 32'(bus.dig_out), 32'd0);
            bus.digging[o] = (d <= 1 && t >= 1 + d && t <= d + L);
            bus.dead       = base_dead | ((k >= 0 && t >= k) ? ev : '0);
            @(negedge clk);
        end
        chk({tag, ".no_early_pulse"}, 32'(early), 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'(is_done));
        chk({tag, ".abort"}, 32'(bus.abort), 32'(!is_done));
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'(is_done));
        chk({tag, ".owner_end"}, 32'(bus.owner), 32'(o));
        if (is_done) mlen = (L > 255) ? 8'd255 : 8'(L);
        chk({tag, ".last_len"}, 32'(bus.last_len), 32'(mlen));
        mptr     = (o + 1) % N;
        done_cyc = is_done ? cyc : -1;
        bus.digging = '0;
        bus.dead    = base_dead;
        @(negedge clk);
        chk({tag, ".pulse_width"}, 32'(bus.done | bus.abort), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rq, dd;
        int           rd, rl, rk;
        bit           got;
        areset      = 1'b1;
        bus.dig_req = '0;
        bus.digging = '0;
        bus.dead    = '0;
        repeat (3) @(negedge clk);
        chk("rst.dig_out", 32'(bus.dig_out), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.owner", 32'(bus.owner), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.abort", 32'(bus.abort), 32'd0);
        chk("rst.last_len", 32'(bus.last_len), 32'd0);
        areset = 1'b0;
        @(negedge clk);
        chk("idle.busy", 32'(bus.busy), 32'd0);

        // Round robin from ptr 0: 0,1,2,3,0
        for (int r = 0; r < 5; r++) begin
            chk("rr.order", 32'(model_pick(4'b1111, mptr)), 32'(r % N));
            session("rr", 4'b1111, '0, 0, 2, -1);
        end
        session("single", 4'b0100, '0, 0, 6, -1);
        session("timeout", 4'b0010, '0, 2, 1, -1);
        session("ptr_after_abort", 4'b0101, '0, 1, 3, -1);
        session("dead_mask", 4'b0011, 4'b0001, 0, 4, 3);
        session("saturate", 4'b0001, '0, 0, 300, -1);

        for (int r = 0; r < 16; r++) begin
            rq = 4'($urandom_range(1, 15));
            dd = 4'($urandom_range(0, 15));
            if ((rq & ~dd) == '0) dd = '0;
            rd = $urandom_range(0, 2);
            rl = $urandom_range(1, 8);
            rk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
            session("rand", rq, dd, rd, rl, rk);
        end

        session("pre_rst", 4'b0100, '0, 0, 2, -1);
        bus.dig_req = 4'b0100;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.dig_out != '0) got = 1'b1;
        end
        chk("arst.issued", 32'(got), 32'd1);
        areset = 1'b1;
        #1;
        chk("arst.dig_out", 32'(bus.dig_out), 32'd0);
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.owner", 32'(bus.owner), 32'd0);
        chk("arst.done_abort", 32'(bus.done | bus.abort), 32'd0);
        chk("arst.last_len", 32'(bus.last_len), 32'd0);
        bus.dig_req = '0;
        @(negedge clk);
        areset   = 1'b0;
        mptr     = 0;
        mlen     = 8'd0;
        done_cyc = -1;
        @(negedge clk);
        session("post_rst", 4'b1010, '0, 0, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
